// File: rtl/tdm_demux8.sv
// Time-division 1-to-8 demultiplexer: steers beat k of each marked frame into
// lane k and presents the completed frame in parallel with a one-cycle strobe.
module tdm_demux8 #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           frame_start,
  output logic [8*W-1:0] dout,
  output logic           dout_valid,
  output logic [2:0]     slot,
  output logic           locked,
  output logic           sync_err
);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_n;
  logic [2:0]       slot_n;
  logic [7*W-1:0]   shadow, shadow_n;   // lane 7 goes straight to dout
  logic [8*W-1:0]   dout_n;
  logic             dout_valid_n;
  logic             sync_err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= 3'd0;
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_n;
      slot       <= slot_n;
      shadow     <= shadow_n;
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
      sync_err   <= sync_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    slot_n       = slot;
    shadow_n     = shadow;
    dout_n       = dout;
    dout_valid_n = 1'b0;
    sync_err_n   = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (frame_start) begin
            shadow_n[W-1:0] = din;
            slot_n          = 3'd1;
            state_n         = RUN;
          end
        end
        RUN: begin
          if (frame_start) begin
            // A marker anywhere but slot 0 abandons the partial frame and resyncs at once.
            sync_err_n      = (slot != 3'd0);
            shadow_n[W-1:0] = din;
            slot_n          = 3'd1;
          end else if (slot == 3'd0) begin
            sync_err_n = 1'b1;
            state_n    = HUNT;
          end else if (slot == 3'd7) begin
            dout_n       = {din, shadow};
            dout_valid_n = 1'b1;
            slot_n       = 3'd0;
          end else begin
            shadow_n[slot*W +: W] = din;
            slot_n                = slot + 3'd1;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  assign locked = (state == RUN);

endmodule

// File: tb/tb_tdm_demux8.sv
// Scoreboarded bench for tdm_demux8 (W=1): expected frames are queued by the
// driver and popped by a monitor whenever dout_valid is seen.
module tb_tdm_demux8;

  localparam int W = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   din;
  logic           din_valid;
  logic           frame_start;
  logic [8*W-1:0] dout;
  logic           dout_valid;
  logic [2:0]     slot;
  logic           locked;
  logic           sync_err;

  tdm_demux8 #(.W(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .frame_start(frame_start), .dout(dout), .dout_valid(dout_valid),
    .slot(slot), .locked(locked), .sync_err(sync_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [8*W-1:0] exp_q[$];
  int             dv_cyc_q[$];
  int             checks = 0;
  int             errors = 0;
  int             err_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every dout_valid pulse must match the oldest queued frame
  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid) begin
        dv_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dout_valid: got dout 0x%0h expected no pulse (cycle %0d)", dout, cyc);
        end else begin
          check("frame_dout", 32'(dout), 32'(exp_q.pop_front()));
        end
      end
      if (sync_err) err_pulses++;
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic beat(input logic d, input logic fs);
    din         = d;
    din_valid   = 1'b1;
    frame_start = fs;
    @(posedge clk);
    #1;
    din_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // sends lanes 0..7 of v; optional gap of gap_len idle cycles after lane gap_after
  task automatic send_frame(input logic [7:0] v, input int gap_after, input int gap_len);
    for (int k = 0; k < 8; k++) begin
      beat(v[k], k == 0);
      if (k == gap_after && gap_len > 0) begin
        idle(gap_len);
        check("slot_hold_in_gap", 32'(slot), 32'(k + 1));
      end
      if (k < 7) check("no_early_valid", 32'(dout_valid), 32'd0);
    end
    check("valid_after_lane7", 32'(dout_valid), 32'd1);
  endtask

  int t0;

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; frame_start = 1'b0;
    #2;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_slot", 32'(slot), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // HUNT discards unmarked beats
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0);
    idle(1);
    check("hunt_locked", 32'(locked), 32'd0);
    check("hunt_slot", 32'(slot), 32'd0);
    check("hunt_err_pulses", 32'(err_pulses), 32'd0);

    // full frame 1,0,1,1,0,0,1,0 -> 8'h4D
    exp_q.push_back(8'h4D);
    send_frame(8'h4D, -1, 0);
    check("f1_dout", 32'(dout), 32'h4D);
    check("f1_locked", 32'(locked), 32'd1);
    check("f1_slot", 32'(slot), 32'd0);
    idle(1);
    check("f1_pulse_one_cycle", 32'(dout_valid), 32'd0);

    // same frame with a 2-cycle gap after lane 3
    exp_q.push_back(8'h4D);
    send_frame(8'h4D, 3, 2);
    check("f2_dout", 32'(dout), 32'h4D);

    // early marker on beat 4, then an all-ones frame
    for (int k = 0; k < 4; k++) beat(1'b0, k == 0);
    exp_q.push_back(8'hFF);
    beat(1'b1, 1'b1);
    check("early_sync_err", 32'(sync_err), 32'd1);
    check("early_no_valid", 32'(dout_valid), 32'd0);
    check("early_dout_held", 32'(dout), 32'h4D);
    check("early_slot", 32'(slot), 32'd1);
    check("early_locked", 32'(locked), 32'd1);
    for (int k = 1; k < 8; k++) beat(1'b1, 1'b0);
    check("ff_valid", 32'(dout_valid), 32'd1);
    check("ff_dout", 32'(dout), 32'hFF);

    // missing marker at slot 0
    beat(1'b1, 1'b0);
    check("miss_sync_err", 32'(sync_err), 32'd1);
    check("miss_locked", 32'(locked), 32'd0);
    check("miss_slot", 32'(slot), 32'd0);
    idle(1);
    check("err_pulses_total", 32'(err_pulses), 32'd2);

    // back-to-back frames, din_valid held high
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    t0 = dv_cyc_q.size();
    send_frame(8'hA5, -1, 0);
    send_frame(8'h3C, -1, 0);
    @(negedge clk);
    #1;
    check("b2b_pulse_count", 32'(dv_cyc_q.size() - t0), 32'd2);
    if (dv_cyc_q.size() - t0 == 2)
      check("b2b_spacing", 32'(dv_cyc_q[t0+1] - dv_cyc_q[t0]), 32'd8);
    check("b2b_dout", 32'(dout), 32'h3C);
    idle(1);

    // asynchronous reset at slot 5
    for (int k = 0; k < 5; k++) beat(1'b1, k == 0);
    check("pre_rst_slot", 32'(slot), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dout", 32'(dout), 32'd0);
    check("async_rst_locked", 32'(locked), 32'd0);
    check("async_rst_slot", 32'(slot), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(2);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Time-division 1-to-8 demultiplexer: the receive-side counterpart of the 8:1 mux lane selector.
- Takes a serial stream of W-bit beats, one beat per valid cycle, tagged with a frame-start marker.
- Steers beat k of each frame into lane k of a shadow register.
- Presents all 8 lanes in parallel, with a one-cycle valid strobe, once a frame completes.
- Sits between a serialised link (an 8x1 mux driven by a slot counter) and parallel consumers.

Parameters:
- W, 1, width of each lane/beat in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  W  serial beat data.
- din_valid  input  1  beat present this cycle.
- frame_start  input  1  qualifies the current beat as lane 0; ignored when din_valid=0.
- dout  output  8*W  parallel frame; lane k occupies dout[k*W +: W].
- dout_valid  output  1  one-cycle pulse, dout just updated.
- slot  output  3  lane index the next accepted beat will be written to ({s2,s1,s0}).
- locked  output  1  1 when in RUN state.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async, immediate): state=HUNT, slot=0, shadow=0, dout=0, dout_valid=0, locked=0, sync_err=0. Reset mid-frame discards the partial frame; dout returns to 0.
- All outputs are registered. dout_valid and sync_err default to 0 each cycle.
- Cycles with din_valid=0: no state change. Gaps inside a frame are allowed and unbounded.
- HUNT state:
  - din_valid=1 with frame_start=0: beat discarded.
  - din_valid=1 with frame_start=1: shadow lane0<=din, slot<=1, go to RUN.
- RUN, din_valid=1, frame_start=0, slot in 1..6: shadow[slot]<=din, slot<=slot+1.
- RUN, din_valid=1, frame_start=0, slot=7:
  - dout<={din, shadow lanes 6..0}; dout_valid<=1; slot<=0 (wrap).
  - Visible the cycle after the capturing edge: latency 1 clock from the lane-7 beat.
- RUN, slot=0, din_valid=1, frame_start=1: normal next frame. Shadow lane0<=din, slot<=1.
- RUN, slot=0, din_valid=1, frame_start=0 (missing marker):
  - sync_err<=1; beat discarded; go to HUNT.
  - slot stays 0; locked<=0.
- RUN, slot 1..7, din_valid=1, frame_start=1 (early marker):
  - sync_err<=1; partial frame discarded with no dout_valid; dout unchanged.
  - Beat taken as lane0, slot<=1; stay in RUN (immediate resync).
- dout holds its last complete frame until the next frame completes.
- Shadow lanes not overwritten after a resync keep stale data but are always rewritten before use.
- The slot wrap from 7 to 0 is mod-8. No partial frame ever produces dout_valid.
- Back-to-back frames with din_valid held high sustain one frame per 8 cycles, with no bubble.

Test Plan:
- Reset, then HUNT behaviour: din_valid=1, frame_start=0 for 5 beats -> locked=0, slot=0, no dout_valid, no sync_err.
- Full frame, W=1: frame_start with beats lane0..7 = 1,0,1,1,0,0,1,0 on consecutive cycles -> one dout_valid pulse the cycle after beat 7, dout=8'h4D, locked=1, slot=0.
- Same frame with din_valid low 2 cycles between beats 3 and 4 -> identical dout=8'h4D, pulse delayed by 2 cycles; slot holds 4 during the gap.
- Early frame_start on beat 4, then a full 8-beat frame of all 1s -> sync_err pulse at the early marker, no dout_valid for the broken frame, then dout=8'hFF. Missing marker at slot 0 -> sync_err, locked=0.
- Two back-to-back frames 8'hA5 then 8'h3C with din_valid always high -> dout_valid pulses exactly 8 cycles apart with those values.
- Assert rst at slot 5 -> dout=0, locked=0, slot=0 immediately, without waiting for a clock edge.
